// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, id type and one-hot helper for the interrupt controller
package irq_pkg;
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h1000_0010;
    typedef logic [4:0] irq_id_t;
    function automatic logic [31:0] onehot(input irq_id_t id);
        return 32'b1 << id;
    endfunction
endpackage

// File: rtl/irq_prio_encoder.sv
// irq_prio_encoder: fixed-priority encoder, lowest set index wins
module irq_prio_encoder #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] elig_i,
    output logic         valid_o,
    output logic [W-1:0] sel_id_o
);
    always_comb begin
        sel_id_o = '0;
        for (int k = N - 1; k >= 0; k--)
            sel_id_o = elig_i[k] ? W'(k) : sel_id_o;
    end
    assign valid_o = |elig_i;
endmodule

// File: rtl/prio_interrupt_controller.sv
// prio_interrupt_controller: fixed-priority multi-channel interrupt arbiter with nesting and edge/level channels
module prio_interrupt_controller
    import irq_pkg::*;
#(
    parameter int                 IRQ_NUM    = 16,
    parameter logic [31:0]        CAUSE_BASE = IRQ_CAUSE_BASE,
    parameter logic [IRQ_NUM-1:0] EDGE_MASK  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic               mie_i,
    input  logic [IRQ_NUM-1:0] irq_mask_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic               irq_ret_o,
    output logic [IRQ_NUM-1:0] irq_ack_o
);
    localparam int IW = IRQ_NUM > 1 ? $clog2(IRQ_NUM) : 1;

    logic               r_exc_h, r_irq_h;
    logic [IW-1:0]      r_active_id;
    logic [IRQ_NUM-1:0] r_pend, r_req_q;
    logic [IRQ_NUM-1:0] w_elig, w_clr, w_rise;
    logic [IW-1:0]      w_sel_id;
    logic               w_valid;

    assign w_elig = ((EDGE_MASK & r_pend) | (~EDGE_MASK & irq_req_i)) & irq_mask_i;

    irq_prio_encoder #(.N(IRQ_NUM), .W(IW)) u_enc (
        .elig_i  (w_elig),
        .valid_o (w_valid),
        .sel_id_o(w_sel_id)
    );

    assign irq_o       = mie_i & w_valid & ~r_exc_h & ~r_irq_h & ~exception_i;
    assign irq_cause_o = CAUSE_BASE + 32'(irq_o ? w_sel_id : r_active_id);
    assign irq_ret_o   = mret_i & ~exception_i & ~r_exc_h & r_irq_h;
    assign irq_ack_o   = irq_ret_o ? IRQ_NUM'(onehot(irq_id_t'(r_active_id))) : '0;
    // a new rising edge is OR-ed in after the grant clear, so set wins
    assign w_clr  = irq_o ? EDGE_MASK & IRQ_NUM'(onehot(irq_id_t'(w_sel_id))) : '0;
    assign w_rise = EDGE_MASK & irq_req_i & ~r_req_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_exc_h     <= 1'b0;
            r_irq_h     <= 1'b0;
            r_active_id <= '0;
            r_pend      <= '0;
            r_req_q     <= '0;
        end else begin
            r_req_q     <= irq_req_i;
            r_pend      <= (r_pend & ~w_clr) | w_rise;
            r_active_id <= irq_o ? w_sel_id : r_active_id;
            r_exc_h     <= exception_i | (r_exc_h & ~mret_i);
            r_irq_h     <= irq_o | (r_irq_h & ~irq_ret_o);
        end
    end
endmodule

// File: tb/tb_prio_interrupt_controller.sv
// tb_prio_interrupt_controller: directed stimulus checked against a behavioural model and literal expectations
module tb_prio_interrupt_controller;
    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h1000_0010;
    localparam logic [15:0] EDGE = 16'h8000;

    logic        clk = 0, rst_i = 1, exception_i = 0, mret_i = 0, mie_i = 0;
    logic [15:0] irq_mask_i = 0, irq_req_i = 0;
    logic        irq_o, irq_ret_o;
    logic [31:0] irq_cause_o;
    logic [15:0] irq_ack_o;
    int          checks = 0, errors = 0;

    prio_interrupt_controller #(.IRQ_NUM(N), .CAUSE_BASE(BASE), .EDGE_MASK(EDGE)) dut (
        .clk_i(clk), .rst_i(rst_i), .exception_i(exception_i), .mret_i(mret_i),
        .mie_i(mie_i), .irq_mask_i(irq_mask_i), .irq_req_i(irq_req_i),
        .irq_o(irq_o), .irq_cause_o(irq_cause_o), .irq_ret_o(irq_ret_o), .irq_ack_o(irq_ack_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // model state: handler flags, serviced channel, latched edges, previous request sample
    bit      m_exc, m_irq;
    int      m_active;
    bit [15:0] m_pend, m_prev;

    always @(negedge clk) begin
        int  sel;
        bit  e_irq, e_ret;
        logic [31:0] e_cause;
        logic [15:0] e_ack;
        sel = -1;
        for (int k = 0; k < N; k++) begin
            bit active;
            active = EDGE[k] ? m_pend[k] : irq_req_i[k];
            if (sel < 0 && active && irq_mask_i[k]) sel = k;
        end
        e_irq   = mie_i && sel >= 0 && !m_exc && !m_irq && !exception_i;
        e_cause = BASE + (e_irq ? sel : m_active);
        e_ret   = mret_i && !exception_i && !m_exc && m_irq;
        e_ack   = e_ret ? 16'(1 << m_active) : 16'h0;
        chk("model_irq", 32'(irq_o), 32'(e_irq));
        chk("model_cause", irq_cause_o, e_cause);
        chk("model_ret", 32'(irq_ret_o), 32'(e_ret));
        chk("model_ack", 32'(irq_ack_o), 32'(e_ack));
        if (rst_i) begin
            m_exc = 0; m_irq = 0; m_active = 0; m_pend = 0; m_prev = 0;
        end else begin
            if (e_irq) begin
                m_active = sel;
                m_irq = 1;
                if (EDGE[sel]) m_pend[sel] = 0;
            end
            for (int k = 0; k < N; k++)
                if (EDGE[k] && irq_req_i[k] && !m_prev[k]) m_pend[k] = 1;
            m_prev = irq_req_i;
            if (exception_i) m_exc = 1;
            else if (mret_i && m_exc) m_exc = 0;
            else if (e_ret) m_irq = 0;
        end
    end

    task automatic cyc(input bit r, input bit e, input bit m, input bit mi,
                       input logic [15:0] mk, input logic [15:0] rq);
        @(posedge clk); #1;
        rst_i = r; exception_i = e; mret_i = m; mie_i = mi; irq_mask_i = mk; irq_req_i = rq;
        @(negedge clk); #2;
    endtask

    initial begin
        cyc(1, 0, 0, 0, 16'h0000, 16'h0000);
        chk("rst_irq", 32'(irq_o), 0);
        chk("rst_cause", irq_cause_o, 32'h1000_0010);
        chk("rst_ret", 32'(irq_ret_o), 0);
        chk("rst_ack", 32'(irq_ack_o), 0);
        // T2: gated by mie or mask
        cyc(0, 0, 0, 0, 16'hFFFF, 16'h0001);
        chk("t2_mie_irq", 32'(irq_o), 0);
        chk("t2_mie_cause", irq_cause_o, 32'h1000_0010);
        cyc(0, 0, 0, 1, 16'h0000, 16'h0001);
        chk("t2_mask_irq", 32'(irq_o), 0);
        // T1: priority, lowest wins
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0014);
        chk("t1_irq", 32'(irq_o), 1);
        chk("t1_cause", irq_cause_o, 32'h1000_0012);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0014);
        chk("t1_hold", 32'(irq_o), 0);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t1_ack", 32'(irq_ack_o), 32'h0004);
        // T3
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0010);
        chk("t3_cause", irq_cause_o, 32'h1000_0014);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t3_ret", 32'(irq_ret_o), 1);
        chk("t3_ack", 32'(irq_ack_o), 32'h0010);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0010);
        chk("t3_regrant", 32'(irq_o), 1);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        // T4: nested exception
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0004);
        chk("t4_irq", 32'(irq_o), 1);
        cyc(0, 1, 0, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t4_ret_exc", 32'(irq_ret_o), 0);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t4_ret", 32'(irq_ret_o), 1);
        chk("t4_ack", 32'(irq_ack_o), 32'h0004);
        // T5: exception beats request
        cyc(0, 1, 0, 1, 16'hFFFF, 16'h0001);
        chk("t5_block", 32'(irq_o), 0);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0001);
        chk("t5_still_exc", 32'(irq_o), 0);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0001);
        chk("t5_irq", 32'(irq_o), 1);
        chk("t5_cause", irq_cause_o, 32'h1000_0010);
        // mret together with exception: exception wins
        cyc(0, 1, 1, 1, 16'hFFFF, 16'h0000);
        chk("mx_ret", 32'(irq_ret_o), 0);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("mx_ret2", 32'(irq_ret_o), 0);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("mx_ack", 32'(irq_ack_o), 32'h0001);
        // T6: edge channel 15 pulse while handling
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0001);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h8000);
        chk("t6_pulse", 32'(irq_o), 0);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t6_ack0", 32'(irq_ack_o), 32'h0001);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0000);
        chk("t6_irq", 32'(irq_o), 1);
        chk("t6_cause", irq_cause_o, 32'h1000_001F);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        chk("t6_ack15", 32'(irq_ack_o), 32'h8000);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0000);
        chk("t6_cleared", 32'(irq_o), 0);
        // rising edge in the grant cycle keeps channel 15 pending
        cyc(0, 0, 0, 0, 16'hFFFF, 16'h8000);
        cyc(0, 0, 0, 0, 16'hFFFF, 16'h0000);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h8000);
        chk("sw_grant", 32'(irq_o), 1);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0000);
        chk("sw_refire", 32'(irq_o), 1);
        // reset mid-handling
        cyc(1, 0, 0, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0000);
        chk("rst_mid_irq", 32'(irq_o), 0);
        chk("rst_mid_cause", irq_cause_o, 32'h1000_0010);
        cyc(0, 0, 0, 1, 16'hFFFF, 16'h0004);
        chk("rst_mid_grant", 32'(irq_o), 1);
        chk("rst_mid_gcause", irq_cause_o, 32'h1000_0012);
        cyc(0, 0, 1, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000, 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
